// File: rtl/i2c_target_regs_if.sv
// Bus-side bundle of the I2C target: pin levels in, open-drain SDA enable and
// register-file status out.
interface i2c_target_regs_if;
  logic        scl_in;
  logic        sda_in;
  logic        sda_oe;
  logic [31:0] regs_out;
  logic        wr_strobe;
  logic [1:0]  wr_index;
  logic        busy;

  modport master (
    output scl_in, sda_in,
    input  sda_oe, regs_out, wr_strobe, wr_index, busy
  );

  modport slave (
    input  scl_in, sda_in,
    output sda_oe, regs_out, wr_strobe, wr_index, busy
  );
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target with a four-entry 8-bit register file and an auto-incrementing
// pointer; never stretches SCL, drives SDA only through sda_oe.
module i2c_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  i2c_target_regs_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t      state_reg;
  logic        scl_s1_reg, scl_s2_reg, scl_d_reg;
  logic        sda_s1_reg, sda_s2_reg, sda_d_reg;
  logic [7:0]  shift_reg;
  logic [7:0]  tx_reg;
  logic [2:0]  bit_cnt_reg;
  logic [1:0]  ptr_reg;
  logic        rw_reg;
  logic        ack_phase_reg;
  logic        sda_oe_reg;
  logic        busy_reg;
  logic        wr_strobe_reg;
  logic [1:0]  wr_index_reg;
  logic [7:0]  regs_mem [4];

  logic       scl_rise, scl_fall, start_evt, stop_evt;
  logic [7:0] byte_next;
  logic [1:0] ptr_next;

  // Synchronisers idle high so release from reset never looks like an edge.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      scl_s1_reg <= 1'b1;
      scl_s2_reg <= 1'b1;
      scl_d_reg  <= 1'b1;
      sda_s1_reg <= 1'b1;
      sda_s2_reg <= 1'b1;
      sda_d_reg  <= 1'b1;
    end else begin
      scl_s1_reg <= bus.scl_in;
      scl_s2_reg <= scl_s1_reg;
      scl_d_reg  <= scl_s2_reg;
      sda_s1_reg <= bus.sda_in;
      sda_s2_reg <= sda_s1_reg;
      sda_d_reg  <= sda_s2_reg;
    end
  end

  assign scl_rise  = scl_s2_reg & ~scl_d_reg;
  assign scl_fall  = ~scl_s2_reg & scl_d_reg;
  assign start_evt = scl_s2_reg & scl_d_reg & ~sda_s2_reg & sda_d_reg;
  assign stop_evt  = scl_s2_reg & scl_d_reg & sda_s2_reg & ~sda_d_reg;
  assign byte_next = {shift_reg[6:0], sda_s2_reg};
  assign ptr_next  = ptr_reg + 2'd1;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      tx_reg        <= '0;
      bit_cnt_reg   <= '0;
      ptr_reg       <= '0;
      rw_reg        <= 1'b0;
      ack_phase_reg <= 1'b0;
      sda_oe_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_index_reg  <= '0;
      for (int i = 0; i < 4; i++) regs_mem[i] <= '0;
    end else begin
      wr_strobe_reg <= 1'b0;
      if (start_evt) begin
        state_reg     <= ADDR;
        bit_cnt_reg   <= '0;
        ack_phase_reg <= 1'b0;
        sda_oe_reg    <= 1'b0;
        busy_reg      <= 1'b0;
      end else if (stop_evt) begin
        state_reg     <= IDLE;
        ack_phase_reg <= 1'b0;
        sda_oe_reg    <= 1'b0;
        busy_reg      <= 1'b0;
      end else begin
        case (state_reg)
          ADDR, PTR, WDATA: begin
            if (scl_rise) begin
              shift_reg   <= byte_next;
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
                if (state_reg == ADDR) begin
                  if (byte_next[7:1] == TARGET_ADDR) begin
                    state_reg <= ADDR_ACK;
                    rw_reg    <= byte_next[0];
                    busy_reg  <= 1'b1;
                  end else begin
                    state_reg <= IGNORE;
                  end
                end else if (state_reg == PTR) begin
                  ptr_reg   <= byte_next[1:0];
                  state_reg <= PTR_ACK;
                end else begin
                  regs_mem[ptr_reg] <= byte_next;
                  wr_strobe_reg     <= 1'b1;
                  wr_index_reg      <= ptr_reg;
                  ptr_reg           <= ptr_next;
                  state_reg         <= WDATA_ACK;
                end
              end
            end
          end
          // First SCL fall asserts the ACK, the second ends it and leaves the state.
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              if (!ack_phase_reg) begin
                sda_oe_reg    <= 1'b1;
                ack_phase_reg <= 1'b1;
              end else begin
                ack_phase_reg <= 1'b0;
                bit_cnt_reg   <= '0;
                if (state_reg == ADDR_ACK && rw_reg) begin
                  state_reg  <= RDATA;
                  sda_oe_reg <= ~regs_mem[ptr_reg][7];
                  tx_reg     <= {regs_mem[ptr_reg][6:0], 1'b0};
                end else begin
                  sda_oe_reg <= 1'b0;
                  state_reg  <= (state_reg == ADDR_ACK) ? PTR : WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (scl_fall) begin
              sda_oe_reg <= ~tx_reg[7];
              tx_reg     <= {tx_reg[6:0], 1'b0};
            end else if (scl_rise) begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) state_reg <= RDATA_ACK;
            end
          end
          // Release for the master's ACK bit, then sample it on the rise.
          RDATA_ACK: begin
            if (scl_fall && !ack_phase_reg) begin
              sda_oe_reg    <= 1'b0;
              ack_phase_reg <= 1'b1;
            end else if (scl_rise && ack_phase_reg) begin
              ack_phase_reg <= 1'b0;
              bit_cnt_reg   <= '0;
              if (!sda_s2_reg) begin
                ptr_reg   <= ptr_next;
                tx_reg    <= regs_mem[ptr_next];
                state_reg <= RDATA;
              end else begin
                state_reg <= IGNORE;
                busy_reg  <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_regs_out
      assign bus.regs_out[gi*8 +: 8] = regs_mem[gi];
    end
  endgenerate

  assign bus.sda_oe    = sda_oe_reg;
  assign bus.busy      = busy_reg;
  assign bus.wr_strobe = wr_strobe_reg;
  assign bus.wr_index  = wr_index_reg;

endmodule
